// File: rtl/ip_uart_tx_arbiter_if.sv
// Producer-side and UART-side signal bundle for ip_uart_tx_arbiter.
interface ip_uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           uart_data;
  logic                 uart_req;
  logic                 uart_busy;
  logic [2:0]           grant_id;
  logic                 locked;
  logic                 timeout_err;
  logic                 err_clear;

  modport slave (
    input  req_valid, req_data, req_last,
    input  uart_busy, err_clear,
    output req_ready, uart_data, uart_req,
    output grant_id, locked, timeout_err
  );

  modport master (
    output req_valid, req_data, req_last,
    output uart_busy, err_clear,
    input  req_ready, uart_data, uart_req,
    input  grant_id, locked, timeout_err
  );
endinterface

// File: rtl/ip_uart_tx_arbiter.sv
// Round-robin arbiter sharing one TX-only UART core between byte producers.
// Grants are held per message; stalled handshakes and idle locks time out.
module ip_uart_tx_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ACK_TIMEOUT  = 255,
  parameter int LOCK_TIMEOUT = 4095
) (
  input logic clk,
  input logic reset,
  ip_uart_tx_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN
  } state_t;

  localparam logic [2:0]  LAST_ID  = 3'(NUM_REQ - 1);
  localparam logic [15:0] ACK_END  = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] LOCK_END = 16'(LOCK_TIMEOUT - 1);

  state_t r_state;
  state_t w_next;

  logic [7:0]  r_data;
  logic        r_last;
  logic [2:0]  r_grant;
  logic [2:0]  r_rr;
  logic        r_locked;
  logic        r_terr;
  logic [15:0] r_ack_cnt;
  logic [15:0] r_lock_cnt;

  logic [NUM_REQ-1:0] w_own_oh;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_low;
  logic [NUM_REQ-1:0] w_sel_oh;
  logic [2:0]         w_sel;
  logic [7:0]         w_sel_data;
  logic               w_sel_last;
  logic [2:0]         w_grant_inc;
  logic               w_found;
  logic               w_xfer;
  logic               w_own_idle;
  logic               w_lock_to;
  logic               w_ack_to;
  logic               w_done;

  assign w_grant_inc = (r_grant == LAST_ID) ? 3'd0 : r_grant + 3'd1;
  assign w_own_oh    = NUM_REQ'(1) << r_grant;
  assign w_cand      = r_locked ? (bus.req_valid & w_own_oh)
                                : bus.req_valid;

  // Rotate so rr_ptr sits at bit 0, keep the lowest set bit, rotate back.
  assign w_rot    = NUM_REQ'({w_cand, w_cand} >> r_rr);
  assign w_low    = w_rot & (~w_rot + NUM_REQ'(1));
  assign w_sel_oh = NUM_REQ'(({w_low, w_low} << r_rr) >> NUM_REQ);
  assign w_found  = |w_cand;

  always_comb begin
    w_sel      = '0;
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel_oh[i]) begin
        w_sel      = w_sel | 3'(i);
        w_sel_data = bus.req_data[8*i +: 8];
        w_sel_last = bus.req_last[i];
      end
    end
  end

  assign w_xfer     = (r_state == S_IDLE) && w_found;
  assign w_own_idle = r_locked && !(|(bus.req_valid & w_own_oh));
  assign w_lock_to  = (r_state == S_IDLE) && w_own_idle &&
                      (r_lock_cnt == LOCK_END);
  assign w_ack_to   = (r_state == S_REQ) && !bus.uart_busy &&
                      (r_ack_cnt == ACK_END);
  assign w_done     = (r_state == S_DRAIN) && !bus.uart_busy;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_xfer) w_next = S_REQ;
      S_REQ: begin
        if (bus.uart_busy)  w_next = S_DRAIN;
        else if (w_ack_to)  w_next = S_IDLE;
      end
      S_DRAIN: if (!bus.uart_busy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data     <= '0;
      r_last     <= 1'b0;
      r_grant    <= '0;
      r_rr       <= '0;
      r_locked   <= 1'b0;
      r_terr     <= 1'b0;
      r_ack_cnt  <= '0;
      r_lock_cnt <= '0;
    end else begin
      if (w_xfer) begin
        r_data  <= w_sel_data;
        r_last  <= w_sel_last;
        r_grant <= w_sel;
      end

      if (w_xfer)
        r_ack_cnt <= '0;
      else if (r_state == S_REQ && !bus.uart_busy)
        r_ack_cnt <= r_ack_cnt + 16'd1;

      if (w_ack_to || w_lock_to || (w_done && r_last)) begin
        r_locked <= 1'b0;
        r_rr     <= w_grant_inc;
      end else if (w_done) begin
        r_locked <= 1'b1;
      end

      if (w_xfer || w_lock_to || !r_locked)
        r_lock_cnt <= '0;
      else if (r_state == S_IDLE && w_own_idle)
        r_lock_cnt <= r_lock_cnt + 16'd1;

      // A timeout in the same cycle as err_clear must stay visible.
      if (w_ack_to)           r_terr <= 1'b1;
      else if (bus.err_clear) r_terr <= 1'b0;
    end
  end

  assign bus.req_ready   = (r_state == S_IDLE) ? w_sel_oh : '0;
  assign bus.uart_req    = (r_state == S_REQ);
  assign bus.uart_data   = r_data;
  assign bus.grant_id    = r_grant;
  assign bus.locked      = r_locked;
  assign bus.timeout_err = r_terr;
endmodule
